sha256_scheduler: RTL and testbench
===================================

SHA256_SCHEDULER -- requirements
Module: sha256_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 4, number of public-key requesters sharing one sha256 core (2..8).
REQ-002 Parameter: WATCHDOG, 96, max cycles in WAIT before abort.
REQ-003 Port: clk  input  1  sole clock; all logic on posedge.
REQ-004 Port: rx_reset  input  1  synchronous, active-high reset.
REQ-005 Port: rx_valid  input  NUM_REQ  per-requester key-valid.
REQ-006 Port: rx_public_key  input  NUM_REQ*264  per-requester compressed key; slice i = [264*i+263 : 264*i].
REQ-007 Port: rx_ready  output  NUM_REQ  one-hot grant; key i accepted on the edge where rx_valid[i] and rx_ready[i] are both high.
REQ-008 Port: core_reset  output  1  drives the sha256 core's rx_reset.
REQ-009 Port: core_public_key  output  264  drives the sha256 core's rx_public_key.
REQ-010 Port: core_done  input  1  the sha256 core's tx_done.
REQ-011 Port: core_hash  input  256  the sha256 core's tx_hash.
REQ-012 Port: tx_valid  output  1  result valid.
REQ-013 Port: tx_ready  input  1  downstream accepts result.
REQ-014 Port: tx_hash  output  256  hash result.
REQ-015 Port: tx_id  output  3  index of the requester that produced tx_hash.
REQ-016 Port: tx_error  output  1  sticky watchdog-abort flag.

Function
REQ-017 FSM states IDLE, LOAD, WAIT, OUT; exactly one is active.
REQ-018 IDLE: rx_ready is one-hot on the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ; it is all-zero when no rx_valid bit is set.
REQ-019 On accept, key and index are registered, rr_ptr becomes (granted index + 1) mod NUM_REQ, and the FSM moves to LOAD.
REQ-020 rx_ready is all-zero in LOAD, WAIT and OUT; at most one key is in flight.
REQ-021 LOAD lasts exactly one cycle: core_reset=1, core_public_key = registered key; the FSM then moves to WAIT.
REQ-022 WAIT: core_reset=0 and a cycle counter increments; when core_done=1, core_hash and the index are captured into tx_hash/tx_id and the FSM moves to OUT.
REQ-023 Latency: with the core's 65-cycle done latency, tx_valid rises on the 67th edge after the accept edge.
REQ-024 OUT: tx_valid=1 and tx_hash/tx_id are held stable until the edge where tx_ready=1; the FSM then moves to IDLE and tx_valid=0.
REQ-025 Back-to-back: a requester whose rx_valid is held gets the next grant only after the other valid requesters have each been served once.
REQ-026 Watchdog: if the WAIT counter reaches WATCHDOG without core_done, set tx_error=1, move to IDLE and discard the result; tx_error clears only on rx_reset.
REQ-027 core_done is ignored outside WAIT; a stale high core_done in the LOAD cycle is not sampled.
REQ-028 core_public_key holds the last loaded key when not in LOAD; it is 0 after reset.

Reset
REQ-029 While rx_reset=1: the FSM goes to IDLE (from any state, including mid-WAIT or OUT), rr_ptr=0, counter=0, tx_valid=0, tx_hash=0, tx_id=0, tx_error=0, rx_ready=0, and core_reset=1.
REQ-030 rx_reset has priority over every other event in the same cycle; an in-flight result is dropped.

Structure
REQ-031 NUM_REQ limits, WATCHDOG default, state encoding and the 264-bit key width live in a shared package (sha256_pkg).
REQ-032 The round-robin priority pick is one sub-module, rr_arbiter (request vector, pointer -> one-hot grant); the sha256 core is instantiated outside this block.

Verification
REQ-033 Single request: rx_valid=0001 with key 02||00..00 -> rx_ready=0001 for 1 cycle, core_reset pulse of exactly 1 cycle, tx_valid on the 67th edge, tx_id=0, tx_hash equal to the reference SHA-256 of the 33-byte key.
REQ-034 All four requesters held valid for 8 jobs -> tx_id sequence 0,1,2,3,0,1,2,3, with no grant overlap.
REQ-035 Backpressure: tx_ready=0 for 20 cycles in OUT -> tx_valid, tx_hash and tx_id are stable throughout, with no new grant; tx_ready=1 -> IDLE on the next edge.
REQ-036 Core model never asserts core_done -> tx_error=1 after 96 WAIT cycles, FSM returns to IDLE, and the next request completes normally.
REQ-037 rx_reset pulsed mid-WAIT -> core_reset=1, tx_valid=0, rr_ptr=0 and no result emitted; the next request is granted to requester 0 first.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and result payload for the sha256 request scheduler.
package sha256_pkg;

   localparam int unsigned KEY_W        = 264;
   localparam int unsigned HASH_W       = 256;
   localparam int unsigned ID_W         = 3;
   localparam int unsigned ID_XW        = ID_W + 1;
   localparam int unsigned NUM_REQ_MIN  = 2;
   localparam int unsigned NUM_REQ_MAX  = 8;
   localparam int unsigned NUM_REQ_DEF  = 4;
   localparam int unsigned WATCHDOG_DEF = 96;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [HASH_W-1:0] hash;
   } result_t;

   // Next round-robin index: idx + 1, wrapping to zero at n.
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx,
                                                input int unsigned     n);
      logic [ID_XW-1:0] nxt;
      nxt = {1'b0, idx} + ID_XW'(1);
      if (nxt >= ID_XW'(n)) begin
         nxt = '0;
      end
      return nxt[ID_W-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter
   import sha256_pkg::*;
#(
   parameter int unsigned N = NUM_REQ_DEF
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [ID_W-1:0] gnt_idx_o,
   output logic            gnt_any_o
);

   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic [ID_XW-1:0] sum;

   // Rotate requests so ptr_i lands at bit 0, then take the lowest set bit.
   always_comb begin
      dbl       = {req_i, req_i} >> ptr_i;
      rot       = dbl[N-1:0];
      sum       = '0;
      gnt_any_o = 1'b0;
      gnt_idx_o = '0;
      gnt_o     = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!gnt_any_o && rot[j]) begin
            gnt_any_o = 1'b1;
            sum       = ID_XW'(ptr_i) + ID_XW'(j);
            if (sum >= ID_XW'(N)) begin
               sum = sum - ID_XW'(N);
            end
            gnt_idx_o = sum[ID_W-1:0];
         end
      end
      if (gnt_any_o) begin
         gnt_o = N'(1) << gnt_idx_o;
      end
   end

endmodule

// File: rtl/sha256_scheduler.sv
// Shares one sha256 core among NUM_REQ public-key requesters, one job in flight.
module sha256_scheduler
   import sha256_pkg::*;
#(
   parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
   parameter int unsigned WATCHDOG = WATCHDOG_DEF
) (
   input  logic                     clk,
   input  logic                     rx_reset,
   input  logic [NUM_REQ-1:0]       rx_valid,
   input  logic [NUM_REQ*KEY_W-1:0] rx_public_key,
   output logic [NUM_REQ-1:0]       rx_ready,
   output logic                     core_reset,
   output logic [KEY_W-1:0]         core_public_key,
   input  logic                     core_done,
   input  logic [HASH_W-1:0]        core_hash,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [HASH_W-1:0]        tx_hash,
   output logic [ID_W-1:0]          tx_id,
   output logic                     tx_error
);

   localparam int unsigned CNT_W = $clog2(WATCHDOG + 1);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [ID_W-1:0]   id_q, id_d;
   result_t           res_q, res_d;
   logic              tx_valid_q, tx_valid_d;
   logic              tx_error_q, tx_error_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic [KEY_W-1:0]   key_sel;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req_i     (rx_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   // Key of the granted requester.
   always_comb begin
      key_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            key_sel = rx_public_key[i*KEY_W +: KEY_W];
         end
      end
   end

   // Handshake-facing outputs; reset forces the core into reset and blocks grants.
   always_comb begin
      rx_ready        = '0;
      core_reset      = rx_reset || (state_q == ST_LOAD);
      core_public_key = key_q;
      tx_valid        = tx_valid_q;
      tx_hash         = res_q.hash;
      tx_id           = res_q.id;
      tx_error        = tx_error_q;
      if (state_q == ST_IDLE && !rx_reset) begin
         rx_ready = gnt;
      end
   end

   // Next-state logic for grant, core load, wait with watchdog, and result hold.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      key_d      = key_q;
      id_d       = id_q;
      res_d      = res_q;
      tx_valid_d = tx_valid_q;
      tx_error_d = tx_error_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               key_d    = key_sel;
               id_d     = gnt_idx;
               rr_ptr_d = wrap_inc(gnt_idx, NUM_REQ);
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A stale core_done here belongs to the previous job and is ignored.
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) begin
               res_d.id   = id_q;
               res_d.hash = core_hash;
               tx_valid_d = 1'b1;
               state_d    = ST_OUT;
            end else if (cnt_q == CNT_W'(WATCHDOG - 1)) begin
               tx_error_d = 1'b1;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_OUT: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; synchronous reset wins over every other event.
   always_ff @(posedge clk) begin
      if (rx_reset) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         key_q      <= '0;
         id_q       <= '0;
         res_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         id_q       <= id_d;
         res_q      <= res_d;
         tx_valid_q <= tx_valid_d;
         tx_error_q <= tx_error_d;
      end
   end

endmodule

// File: tb/tb_sha256_scheduler.sv
// Directed bench for sha256_scheduler with a behavioural 65-cycle core model.
module tb_sha256_scheduler;
   import sha256_pkg::*;

   localparam int unsigned NR = 4;

   logic                clk = 1'b0;
   logic                rx_reset;
   logic [NR-1:0]       rx_valid;
   logic [NR*KEY_W-1:0] rx_public_key;
   logic [NR-1:0]       rx_ready;
   logic                core_reset;
   logic [KEY_W-1:0]    core_public_key;
   logic                core_done = 1'b0;
   logic [HASH_W-1:0]   core_hash;
   logic                tx_valid;
   logic                tx_ready;
   logic [HASH_W-1:0]   tx_hash;
   logic [ID_W-1:0]     tx_id;
   logic                tx_error;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;

   logic             core_dis = 1'b0;
   int               core_cnt = 0;
   logic [KEY_W-1:0] core_key = '0;
   logic [KEY_W-1:0] keys [NR];

   sha256_scheduler #(.NUM_REQ(NR), .WATCHDOG(96)) dut (
      .clk             (clk),
      .rx_reset        (rx_reset),
      .rx_valid        (rx_valid),
      .rx_public_key   (rx_public_key),
      .rx_ready        (rx_ready),
      .core_reset      (core_reset),
      .core_public_key (core_public_key),
      .core_done       (core_done),
      .core_hash       (core_hash),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .tx_hash         (tx_hash),
      .tx_id           (tx_id),
      .tx_error        (tx_error)
   );

   always #5 clk = ~clk;

   // Stand-in digest: distinct per key so the routed key is observable.
   function automatic logic [HASH_W-1:0] model_hash(input logic [KEY_W-1:0] k);
      return k[HASH_W-1:0] ^ {8{32'h9e3779b9}} ^ HASH_W'(k[KEY_W-1:HASH_W]);
   endfunction

   assign core_hash = core_done ? model_hash(core_key) : '0;

   // Core model: latches key during reset, done 65 edges after reset release.
   always @(posedge clk) begin
      if (core_reset) begin
         core_cnt  <= 0;
         core_done <= 1'b0;
         core_key  <= core_public_key;
      end else if (!core_dis && core_cnt < 65) begin
         core_cnt <= core_cnt + 1;
         if (core_cnt == 64) core_done <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until tx_valid, counting edges from 'start'; bounded.
   task automatic wait_valid(input int start, output int n);
      n = start;
      while (!tx_valid && n < 300) begin
         step();
         n++;
         if (rx_ready != '0) overlap++;
      end
   endtask

   initial begin
      int n;
      int hold_tx;
      rx_reset = 1'b1;
      rx_valid = 4'b1111;
      tx_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         keys[i] = {8'(8'h02 + (i % 2)), {8{32'(i) * 32'h01010101}}};
         rx_public_key[i*KEY_W +: KEY_W] = keys[i];
      end

      // Reset state
      step(); step();
      chk("rst_tx_valid", KEY_W'(tx_valid), '0);
      chk("rst_tx_hash", KEY_W'(tx_hash), '0);
      chk("rst_tx_id", KEY_W'(tx_id), '0);
      chk("rst_tx_error", KEY_W'(tx_error), '0);
      chk("rst_rx_ready", KEY_W'(rx_ready), '0);
      chk("rst_core_reset", KEY_W'(core_reset), KEY_W'(1));
      chk("rst_core_key", core_public_key, '0);
      rx_valid = '0;
      rx_reset = 1'b0;
      step();
      chk("idle_core_reset", KEY_W'(core_reset), '0);

      // Single request from requester 0, then backpressure in OUT
      rx_valid = 4'b0001;
      #1;
      chk("single_grant", KEY_W'(rx_ready), KEY_W'(4'b0001));
      step();
      rx_valid = '0;
      #1;
      chk("single_ready_off", KEY_W'(rx_ready), '0);
      chk("load_core_reset", KEY_W'(core_reset), KEY_W'(1));
      chk("load_core_key", core_public_key, keys[0]);
      step();
      chk("wait_core_reset", KEY_W'(core_reset), '0);
      chk("wait_core_key", core_public_key, keys[0]);
      wait_valid(1, n);
      chk("single_latency", KEY_W'(n), KEY_W'(67));
      chk("single_id", KEY_W'(tx_id), '0);
      chk("single_hash", KEY_W'(tx_hash), KEY_W'({8{32'h9e3779b9}} ^ 256'h02));
      rx_valid = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("bp_hold", KEY_W'({tx_valid, tx_id, rx_ready}), KEY_W'({1'b1, 3'd0, 4'b0000}));
         chk("bp_hash", KEY_W'(tx_hash), KEY_W'(model_hash(keys[0])));
      end
      rx_valid = '0;
      tx_ready = 1'b1;
      step();
      chk("bp_release", KEY_W'(tx_valid), '0);
      rx_valid = 4'b1111;
      #1;
      chk("rr_ptr_after_0", KEY_W'(rx_ready), KEY_W'(4'b0010));
      rx_valid = '0;

      // Round robin with all requesters held valid for 8 jobs
      rx_reset = 1'b1;
      step();
      rx_reset = 1'b0;
      rx_valid = 4'b1111;
      overlap = 0;
      #1;
      for (int j = 0; j < 8; j++) begin
         chk("rr_grant", KEY_W'(rx_ready), KEY_W'(1) << (j % 4));
         step();
         wait_valid(0, n);
         chk("rr_latency", KEY_W'(n), KEY_W'(67));
         chk("rr_id", KEY_W'(tx_id), KEY_W'(j % 4));
         chk("rr_hash", KEY_W'(tx_hash), KEY_W'(model_hash(keys[j % 4])));
         if (j == 7) rx_valid = '0;
         step();
      end
      chk("rr_no_overlap", KEY_W'(overlap), '0);
      chk("rr_out_done", KEY_W'(tx_valid), '0);

      // Watchdog abort when the core never finishes
      core_dis = 1'b1;
      rx_valid = 4'b0100;
      #1;
      chk("wd_grant", KEY_W'(rx_ready), KEY_W'(4'b0100));
      step();
      rx_valid = '0;
      step();
      for (int c = 0; c < 95; c++) step();
      chk("wd_before", KEY_W'(tx_error), '0);
      step();
      chk("wd_error", KEY_W'(tx_error), KEY_W'(1));
      chk("wd_no_valid", KEY_W'(tx_valid), '0);
      rx_valid = 4'b0001;
      #1;
      chk("wd_idle_grant", KEY_W'(rx_ready), KEY_W'(4'b0001));
      core_dis = 1'b0;
      step();
      rx_valid = '0;
      wait_valid(0, n);
      chk("wd_next_latency", KEY_W'(n), KEY_W'(67));
      chk("wd_next_id", KEY_W'(tx_id), '0);
      chk("wd_next_hash", KEY_W'(tx_hash), KEY_W'(model_hash(keys[0])));
      chk("wd_sticky", KEY_W'(tx_error), KEY_W'(1));
      step();

      // Reset pulsed mid-WAIT drops the job and restarts priority at 0
      rx_valid = 4'b1111;
      #1;
      chk("mid_grant", KEY_W'(rx_ready), KEY_W'(4'b0010));
      step();
      rx_valid = '0;
      for (int c = 0; c < 10; c++) step();
      rx_reset = 1'b1;
      #1;
      chk("mid_core_reset", KEY_W'(core_reset), KEY_W'(1));
      step();
      chk("mid_tx_valid", KEY_W'(tx_valid), '0);
      chk("mid_tx_error", KEY_W'(tx_error), '0);
      chk("mid_core_key", core_public_key, '0);
      rx_reset = 1'b0;
      hold_tx = 0;
      for (int c = 0; c < 80; c++) begin
         step();
         if (tx_valid) hold_tx++;
      end
      chk("mid_no_result", KEY_W'(hold_tx), '0);
      rx_valid = 4'b1111;
      #1;
      chk("mid_ptr_zero", KEY_W'(rx_ready), KEY_W'(4'b0001));
      step();
      rx_valid = '0;
      wait_valid(0, n);
      chk("mid_next_latency", KEY_W'(n), KEY_W'(67));
      chk("mid_next_id", KEY_W'(tx_id), '0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
